// File: rtl/data_ram_if.sv
// ----------------------------------------------------------------------------
// data_ram_if
//   Request/response bundle between the CPU MEM stage and data_ram_ctrl.
//   master : issues requests (valid, write, byte_en, addr, store_data) and
//            observes the response (data_o, busy, done, err).
//   slave  : the memory controller side.
//   byte_en carries the per-lane byte enables: lane i targets addr+i and
//   data bits [8i+7:8i].
// ----------------------------------------------------------------------------
interface data_ram_if;
    logic        valid;
    logic        write;
    logic [3:0]  byte_en;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] data_o;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output valid, write, byte_en, addr, store_data,
        input  data_o, busy, done, err
    );

    modport slave (
        input  valid, write, byte_en, addr, store_data,
        output data_o, busy, done, err
    );
endinterface

// File: rtl/data_ram_ctrl.sv
// ----------------------------------------------------------------------------
// data_ram_ctrl
//   Clocked, byte-addressable data memory for the CPU MEM stage with
//   per-lane byte enables, unaligned lane addressing and a fixed number of
//   wait states. A request is accepted in IDLE, held in BUSY for
//   WAIT_CYCLES cycles, then committed; completion is a one-cycle done pulse.
//   Accesses touching any byte at or beyond DEPTH_BYTES are flagged with err
//   and suppressed entirely.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (memory contents are kept)
//   bus    : data_ram_if.slave
//            valid/write/byte_en/addr/store_data - request, sampled when
//                                                  valid && !busy
//            data_o - load result, valid with done, held until next commit
//            busy   - access in flight, requests ignored
//            done   - one-cycle completion pulse
//            err    - range error, qualified by done
// ----------------------------------------------------------------------------
module data_ram_ctrl #(
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_W      = $clog2(DEPTH_BYTES),
    parameter int WAIT_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    data_ram_if.slave  bus
);

    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;

    // Latched request; the bus inputs are free to change after acceptance.
    logic               req_write;
    logic [3:0]         req_byte;
    logic [31:0]        req_addr;
    logic [31:0]        req_data;

    logic [31:0]        data_q;
    logic               done_q;
    logic               err_q;

    logic               accept;
    logic               commit;

    logic [7:0]         mem [DEPTH_BYTES];

    // Lane addresses carry one extra bit so addr+i never wraps to a small
    // in-range value near the top of the 32-bit space.
    logic [32:0]        lane_addr [4];
    logic               range_err;
    logic [31:0]        rd_data;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, otherwise paths
    // that skip an assignment would infer latches.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.valid) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Lane address generation, range check and load data assembly
    // ------------------------------------------------------------------
    always_comb begin
        range_err = 1'b0;
        rd_data   = '0;
        for (int i = 0; i < 4; i++) begin
            lane_addr[i] = {1'b0, req_addr} + 33'(i);
            if (req_byte[i] && (lane_addr[i] >= 33'(DEPTH_BYTES))) begin
                range_err = 1'b1;
            end
            if (req_byte[i]) begin
                rd_data[8*i +: 8] = mem[lane_addr[i][ADDR_W-1:0]];
            end
        end
    end

    // ------------------------------------------------------------------
    // Request latch, wait counter and registered response
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            req_write <= 1'b0;
            req_byte  <= '0;
            req_addr  <= '0;
            req_data  <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= commit;
            err_q  <= commit && range_err;

            if (accept) begin
                req_write <= bus.write;
                req_byte  <= bus.byte_en;
                req_addr  <= bus.addr;
                req_data  <= bus.store_data;
                cnt_q     <= CNT_W'(WAIT_CYCLES - 1);
            end else if (state_q == BUSY && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end

            // Stores and errored accesses return zero.
            if (commit) begin
                data_q <= (req_write || range_err) ? 32'd0 : rd_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory array write port
    // ------------------------------------------------------------------
    // NOTE: the array has no reset; clearing it would need a per-entry
    // reset network and reset must leave its contents intact anyway.
    always_ff @(posedge clk) begin
        if (commit && req_write && !range_err) begin
            for (int i = 0; i < 4; i++) begin
                if (req_byte[i]) begin
                    mem[lane_addr[i][ADDR_W-1:0]] <= req_data[8*i +: 8];
                end
            end
        end
    end

    assign bus.busy   = (state_q == BUSY);
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.data_o = data_q;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// ----------------------------------------------------------------------------
// tb_data_ram_ctrl
//   Scoreboard bench for data_ram_ctrl. The stimulus thread computes the
//   expected response of every tracked request from a byte-array model and
//   queues it; a monitor pops and compares whenever done is seen.
// ----------------------------------------------------------------------------
module tb_data_ram_ctrl;

    localparam int DEPTH = 1024;
    localparam int WAIT  = 3;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk;
    logic rst_n;

    data_ram_if bus ();

    data_ram_ctrl #(
        .DEPTH_BYTES (DEPTH),
        .ADDR_W      (10),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int    n_checks = 0;
    int    n_errors = 0;
    exp_t  exp_q[$];
    logic [7:0] ref_mem [DEPTH];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Reference semantics: an access is all-or-nothing on range; enabled
    // lanes read or write bytes addr+i, disabled lanes read as zero.
    function automatic void model(input logic wr, input logic [3:0] be,
                                  input logic [31:0] a, input logic [31:0] d,
                                  output logic [31:0] rdata, output logic rerr);
        logic [63:0] la;
        rerr  = 1'b0;
        rdata = '0;
        for (int i = 0; i < 4; i++) begin
            la = {32'd0, a} + 64'(i);
            if (be[i] && la >= 64'(DEPTH)) rerr = 1'b1;
        end
        if (!rerr) begin
            for (int i = 0; i < 4; i++) begin
                la = {32'd0, a} + 64'(i);
                if (be[i]) begin
                    if (wr) ref_mem[la[9:0]] = d[8*i +: 8];
                    else    rdata[8*i +: 8] = ref_mem[la[9:0]];
                end
            end
        end
    endfunction

    // All stimulus runs at posedge+1; wait until the controller is idle.
    task automatic wait_idle();
        int n = 0;
        while (bus.busy) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 100) begin
                n_checks++;
                n_errors++;
                $display("FAIL busy_timeout: busy still 1 after %0d cycles", n);
                return;
            end
        end
    endtask

    task automatic scramble_inputs();
        bus.write      = 1'($urandom);
        bus.byte_en    = 4'($urandom);
        bus.addr       = $urandom;
        bus.store_data = $urandom;
    endtask

    task automatic drive(input logic wr, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] d, input bit track);
        exp_t e;
        bus.valid      = 1'b1;
        bus.write      = wr;
        bus.byte_en    = be;
        bus.addr       = a;
        bus.store_data = d;
        if (track) begin
            model(wr, be, a, d, e.data, e.err);
            exp_q.push_back(e);
        end
    endtask

    task automatic issue(input logic wr, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] d, input bit track);
        wait_idle();
        drive(wr, be, a, d, track);
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        scramble_inputs();
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.done) begin
                check("done_busy_low", 32'(bus.busy), 32'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_done: got done=1, expected no completion at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("data_o", bus.data_o, e.data);
                    check("err", 32'(bus.err), 32'(e.err));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] old_word;
        logic [31:0] a;
        logic [3:0]  be;
        int          r;

        rst_n     = 1'b0;
        bus.valid = 1'b0;
        scramble_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   32'(bus.busy), 32'd0);
        check("rst_done",   32'(bus.done), 32'd0);
        check("rst_err",    32'(bus.err),  32'd0);
        check("rst_data_o", bus.data_o,    32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Preload: give every byte a known value via full-word stores.
        for (int w = 0; w < DEPTH / 4; w++) begin
            issue(1'b1, 4'b1111, 32'(w * 4), $urandom, 1'b1);
        end
        drain();

        // Cycle-exact handshake timing of one store.
        wait_idle();
        drive(1'b1, 4'b1111, 32'h10, 32'hDEAD_BEEF, 1'b1);
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        scramble_inputs();
        for (int k = 1; k <= WAIT; k++) begin
            @(negedge clk);
            check($sformatf("busy_T+%0d", k), 32'(bus.busy), 32'd1);
            check($sformatf("done_T+%0d", k), 32'(bus.done), 32'd0);
        end
        @(negedge clk);
        check("busy_done_cycle", 32'(bus.busy), 32'd0);
        check("done_done_cycle", 32'(bus.done), 32'd1);
        @(posedge clk);
        #1;

        // Partial load of the stored word.
        issue(1'b0, 4'b0011, 32'h10, 32'h0, 1'b1);

        // Unaligned masked store then full load over it.
        issue(1'b1, 4'b1010, 32'h3, 32'h1122_3344, 1'b1);
        issue(1'b0, 4'b1111, 32'h3, 32'h0, 1'b1);

        // Out-of-range accesses at the top of memory.
        issue(1'b0, 4'b1111, 32'h3FE, 32'h0, 1'b1);
        issue(1'b1, 4'b1111, 32'h3FE, 32'hA5A5_A5A5, 1'b1);
        issue(1'b0, 4'b0011, 32'h3FE, 32'h0, 1'b1);
        issue(1'b1, 4'b1000, 32'h3FD, 32'h5A00_0000, 1'b1);
        issue(1'b0, 4'b1111, 32'h3FC, 32'h0, 1'b1);
        issue(1'b0, 4'b0001, 32'hFFFF_FFFF, 32'h0, 1'b1);

        // Empty lane mask.
        issue(1'b1, 4'b0000, 32'h20, 32'hFFFF_FFFF, 1'b1);
        issue(1'b0, 4'b0000, 32'h20, 32'h0, 1'b1);

        // A request pulsed while busy must be dropped.
        issue(1'b1, 4'b1111, 32'h30, 32'h0BAD_F00D, 1'b1);
        drive(1'b1, 4'b1111, 32'h20, 32'hCAFE_CAFE, 1'b0);
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        issue(1'b0, 4'b1111, 32'h20, 32'h0, 1'b1);
        issue(1'b0, 4'b1111, 32'h30, 32'h0, 1'b1);
        drain();

        // Reset in the middle of a store: no completion, memory untouched.
        old_word = {ref_mem[16'h43], ref_mem[16'h42], ref_mem[16'h41], ref_mem[16'h40]};
        issue(1'b1, 4'b1111, 32'h40, ~old_word, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy",   32'(bus.busy), 32'd0);
        check("midrst_done",   32'(bus.done), 32'd0);
        check("midrst_data_o", bus.data_o,    32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        issue(1'b0, 4'b1111, 32'h40, 32'h0, 1'b1);
        drain();

        // Randomised traffic with occasional idle gaps.
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 8)       a = 32'($urandom_range(0, DEPTH - 1));
            else if (r == 8) a = 32'(DEPTH - 4 + int'($urandom_range(0, 7)));
            else             a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            be = 4'($urandom);
            issue(1'($urandom), be, a, $urandom, 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                repeat (int'($urandom_range(1, 3))) @(posedge clk);
                #1;
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
